// File: rtl/regfile_sb.sv
// Integer register file with two write ports, same-cycle write-to-read bypass
// and a per-register scoreboard of in-flight producers for RAW hazard detection.
module regfile_sb #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NUM_RD = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_RD*AW-1:0]     i_rd_addr,
  output logic [NUM_RD*XLEN-1:0]   o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_wa_en,
  input  logic [AW-1:0]            i_wa_addr,
  input  logic [XLEN-1:0]          i_wa_data,
  input  logic                     i_wb_en,
  input  logic [AW-1:0]            i_wb_addr,
  input  logic [XLEN-1:0]          i_wb_data,
  input  logic                     i_iss_en,
  input  logic [AW-1:0]            i_iss_addr,
  output logic [AW:0]              o_busy_cnt
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_busyCnt;
  logic [NREG-1:0] w_busyNext;
  logic [AW:0]     w_busyCntNext;

  // An issue names a newer producer than any write landing in the same cycle,
  // so it wins over the clear.
  always_comb begin
    w_busyNext = r_busy;
    for (int r = 1; r < NREG; r++) begin
      if (i_iss_en && (i_iss_addr == AW'(r))) begin
        w_busyNext[r] = 1'b1;
      end else if ((i_wa_en && (i_wa_addr == AW'(r))) ||
                   (i_wb_en && (i_wb_addr == AW'(r)))) begin
        w_busyNext[r] = 1'b0;
      end
    end
    w_busyNext[0] = 1'b0;
  end

  always_comb begin
    w_busyCntNext = '0;
    for (int r = 0; r < NREG; r++) begin
      w_busyCntNext = w_busyCntNext + {{AW{1'b0}}, w_busyNext[r]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        r_regs[r] <= '0;
      end
      r_busy    <= '0;
      r_busyCnt <= '0;
    end else begin
      if (i_wa_en && (i_wa_addr != '0)) begin
        r_regs[i_wa_addr] <= i_wa_data;
      end
      // Port B is the later assignment, so it wins a same-address collision.
      if (i_wb_en && (i_wb_addr != '0)) begin
        r_regs[i_wb_addr] <= i_wb_data;
      end
      r_busy    <= w_busyNext;
      r_busyCnt <= w_busyCntNext;
    end
  end

  assign o_busy_cnt = r_busyCnt;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_hitA;
    logic          w_hitB;

    assign w_addr = i_rd_addr[k*AW +: AW];
    assign w_hitA = i_wa_en && (i_wa_addr == w_addr);
    assign w_hitB = i_wb_en && (i_wb_addr == w_addr);

    assign o_rd_data[k*XLEN +: XLEN] = (w_addr == '0) ? '0 :
                                       w_hitB         ? i_wb_data :
                                       w_hitA         ? i_wa_data :
                                                        r_regs[w_addr];
    // A write landing this cycle satisfies the reader through the bypass.
    assign o_rd_busy[k] = (w_addr != '0) && r_busy[w_addr] && !w_hitA && !w_hitB;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: reset, writes, bypass,
// scoreboard set/clear, counter saturation at NREG-1, and mid-run reset.
module tb_regfile_sb;

  localparam int XLEN   = 64;
  localparam int NREG   = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = $clog2(NREG);

  logic                   clk;
  logic                   rstN;
  logic [NUM_RD*AW-1:0]   rdAddr;
  logic [NUM_RD*XLEN-1:0] rdData;
  logic [NUM_RD-1:0]      rdBusy;
  logic                   waEn;
  logic [AW-1:0]          waAddr;
  logic [XLEN-1:0]        waData;
  logic                   wbEn;
  logic [AW-1:0]          wbAddr;
  logic [XLEN-1:0]        wbData;
  logic                   issEn;
  logic [AW-1:0]          issAddr;
  logic [AW:0]            busyCnt;

  int checkCount = 0;
  int errorCount = 0;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NUM_RD(NUM_RD)) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_rd_addr  (rdAddr),
    .o_rd_data  (rdData),
    .o_rd_busy  (rdBusy),
    .i_wa_en    (waEn),
    .i_wa_addr  (waAddr),
    .i_wa_data  (waData),
    .i_wb_en    (wbEn),
    .i_wb_addr  (wbAddr),
    .i_wb_data  (wbData),
    .i_iss_en   (issEn),
    .i_iss_addr (issAddr),
    .o_busy_cnt (busyCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Drives every input for the coming cycle, then settles before sampling.
  task automatic applyStimulus(input logic we_a, input int a_addr, input logic [XLEN-1:0] a_data,
                               input logic we_b, input int b_addr, input logic [XLEN-1:0] b_data,
                               input logic iss, input int i_addr,
                               input int r0, input int r1);
    waEn    = we_a;  waAddr = AW'(a_addr); waData = a_data;
    wbEn    = we_b;  wbAddr = AW'(b_addr); wbData = b_data;
    issEn   = iss;   issAddr = AW'(i_addr);
    rdAddr[0*AW +: AW] = AW'(r0);
    rdAddr[1*AW +: AW] = AW'(r1);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] port(input int k);
    return rdData[k*XLEN +: XLEN];
  endfunction

  initial begin
    rstN = 1'b0;
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 0, 0);
    tick();
    tick();
    rstN = 1'b1;

    // Reset state across every address on both ports.
    for (int a = 0; a < NREG; a++) begin
      applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, a, NREG - 1 - a);
      checkOutput("rst_data0", port(0), '0);
      checkOutput("rst_data1", port(1), '0);
      checkOutput("rst_busy", XLEN'(rdBusy), '0);
    end
    checkOutput("rst_cnt", XLEN'(busyCnt), '0);

    // Independent writes on both ports, then read back from the array.
    applyStimulus(1, 5, 64'h1234, 1, 6, 64'hABCD, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 5, 6);
    checkOutput("wr_x5", port(0), 64'h1234);
    checkOutput("wr_x6", port(1), 64'hABCD);
    applyStimulus(1, 0, 64'hFFFF, 0, 0, '0, 0, 0, 0, 0);
    checkOutput("x0_bypass", port(0), '0);
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 0, 5);
    checkOutput("x0_zero", port(0), '0);
    checkOutput("x5_hold", port(1), 64'h1234);

    // Same-address collision: port B wins in bypass and in the array.
    applyStimulus(1, 7, 64'h11, 1, 7, 64'h22, 0, 0, 7, 0);
    checkOutput("x7_bypass", port(0), 64'h22);
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 7, 0);
    checkOutput("x7_array", port(0), 64'h22);

    // Scoreboard issue/clear.
    applyStimulus(0, 0, '0, 0, 0, '0, 1, 3, 0, 0);
    tick();
    checkOutput("cnt_iss3", XLEN'(busyCnt), 64'd1);
    applyStimulus(0, 0, '0, 0, 0, '0, 1, 4, 0, 0);
    tick();
    checkOutput("cnt_iss4", XLEN'(busyCnt), 64'd2);
    applyStimulus(0, 0, '0, 0, 0, '0, 1, 0, 0, 0);
    tick();
    checkOutput("cnt_iss0", XLEN'(busyCnt), 64'd2);
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 3, 0);
    checkOutput("x3_busy", XLEN'(rdBusy[0]), 64'd1);
    checkOutput("x0_notbusy", XLEN'(rdBusy[1]), 64'd0);
    applyStimulus(0, 0, '0, 1, 3, 64'h99, 0, 0, 3, 4);
    checkOutput("x3_bypass", port(0), 64'h99);
    checkOutput("x3_resolved", XLEN'(rdBusy[0]), 64'd0);
    checkOutput("x4_busy", XLEN'(rdBusy[1]), 64'd1);
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 3, 4);
    checkOutput("cnt_clr3", XLEN'(busyCnt), 64'd1);
    checkOutput("x3_clear", XLEN'(rdBusy[0]), 64'd0);

    // Issue and write to the same register: stays busy, data updated.
    applyStimulus(1, 8, 64'h55, 0, 0, '0, 1, 8, 0, 0);
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 8, 0);
    checkOutput("x8_busy", XLEN'(rdBusy[0]), 64'd1);
    checkOutput("x8_data", port(0), 64'h55);
    checkOutput("cnt_iss8", XLEN'(busyCnt), 64'd2);

    // Re-issue to an already-busy register leaves the count alone.
    applyStimulus(0, 0, '0, 0, 0, '0, 1, 4, 0, 0);
    tick();
    checkOutput("cnt_reiss", XLEN'(busyCnt), 64'd2);

    // Saturate: every nonzero register busy, then a two-port clear.
    for (int r = 1; r < NREG; r++) begin
      applyStimulus(0, 0, '0, 0, 0, '0, 1, r, 0, 0);
      tick();
    end
    checkOutput("cnt_full", XLEN'(busyCnt), 64'(NREG - 1));
    applyStimulus(0, 0, '0, 0, 0, '0, 1, 0, 0, 0);
    tick();
    checkOutput("cnt_full_x0", XLEN'(busyCnt), 64'(NREG - 1));
    applyStimulus(1, 12, 64'h1, 1, 13, 64'h2, 0, 0, 0, 0);
    tick();
    checkOutput("cnt_dec2", XLEN'(busyCnt), 64'(NREG - 3));

    // Reset mid-operation beats a concurrent write and discards the scoreboard.
    applyStimulus(0, 0, '0, 0, 0, '0, 1, 9, 0, 0);
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0, 1, 10, 0, 0);
    tick();
    rstN = 1'b0;
    applyStimulus(1, 9, 64'h5, 0, 0, '0, 0, 0, 0, 0);
    tick();
    rstN = 1'b1;
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 9, 5);
    checkOutput("rst2_x9", port(0), '0);
    checkOutput("rst2_x5", port(1), '0);
    checkOutput("rst2_busy", XLEN'(rdBusy), '0);
    checkOutput("rst2_cnt", XLEN'(busyCnt), '0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file for the pipelined RISC-V core, successor to the single-write, two-read register file. Adds a configurable number of read ports, a second write port for the load/writeback path, same-cycle write-to-read bypass, and a per-register scoreboard that tracks in-flight producers so the decode stage can detect RAW hazards. It sits between decode (read/issue) and writeback (ALU and load write ports).

## Interface
- XLEN, 64, register data width
- NREG, 32, number of architectural registers (power of two, >= 2); AW = $clog2(NREG)
- NUM_RD, 2, number of read ports (1..4)
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  reset; one clock; reset is synchronous and active-low
- i_rd_addr  in  NUM_RD*AW  read addresses, port k at bits [k*AW +: AW]
- o_rd_data  out  NUM_RD*XLEN  read data, port k at [k*XLEN +: XLEN]
- o_rd_busy  out  NUM_RD  port k's register has an outstanding producer
- i_wa_en / i_wa_addr / i_wa_data  in  1 / AW / XLEN  write port A (ALU result)
- i_wb_en / i_wb_addr / i_wb_data  in  1 / AW / XLEN  write port B (load result)
- i_iss_en / i_iss_addr  in  1 / AW  issue: mark destination register busy
- o_busy_cnt  out  AW+1  number of registers currently marked busy

## Operation
- Storage: NREG x XLEN array plus NREG-bit busy vector plus registered busy counter.
- Register 0 hardwired zero: writes to 0 ignored, issue to 0 ignored, read of 0 always returns 0 and busy 0.
- Write: on edge, if i_wa_en and addr != 0, store i_wa_data; likewise port B. Both enabled to same nonzero addr: port B wins.
- Read (combinational, per port): if addr == 0 -> 0; else if i_wb_en and i_wb_addr == addr -> i_wb_data; else if i_wa_en and i_wa_addr == addr -> i_wa_data; else array value.
- Scoreboard next state, per register r != 0: set if issue targets r; else clear if any enabled write targets r; else hold. Issue and write to same r in one cycle -> stays busy (issue denotes a newer producer).
- Issue to an already-busy register: stays busy, counter unchanged.
- o_rd_busy[k] = busy[addr] AND NOT (any enabled write to addr this cycle); 0 for addr 0. A write in the same cycle as the read therefore resolves the hazard through the bypass.
- o_busy_cnt: registered; next value = popcount of next busy vector, or equivalent +1/-1/-2/+0 incremental update. Must never exceed NREG-1.

## Timing
- Reset (i_rst_n low at rising edge): all registers 0, all busy bits 0, o_busy_cnt 0. Reset takes precedence over writes and issue in the same cycle. Since reads are combinational, o_rd_data = 0 and o_rd_busy = 0 from the first cycle after reset. Reset mid-operation discards all pending scoreboard state.
- Read latency: 0 cycles (combinational from addresses and write ports); write-to-array visible via array 1 cycle after the edge, via bypass in the same cycle.
- Issue at edge N -> busy visible on o_rd_busy and o_busy_cnt after edge N.
- No handshakes; every enable is single-cycle qualified.

## Test plan
- Reset, then read all NREG addresses on every port -> all data 0, all busy 0, o_busy_cnt 0.
- Write A to x5 = 0x1234 and B to x6 = 0xABCD in one cycle; next cycle read x5, x6 -> 0x1234, 0xABCD; write A x0 = 0xFFFF -> read x0 still 0.
- A and B both write x7 (0x11 / 0x22) same cycle -> same-cycle bypass read 0x22, next cycle array read 0x22.
- Issue x3, x4, x0 on three cycles -> o_busy_cnt 1, 2, 2; read x3 busy=1; B write x3 = 0x99 with simultaneous read of x3 -> data 0x99, busy 0; next cycle o_busy_cnt 1.
- Issue x8 and A write x8 same cycle -> x8 busy after edge, data updated, o_busy_cnt increments.
- Issue x9, x10, then assert i_rst_n low concurrently with a write to x9 = 0x5 -> after edge x9 = 0, no busy bits, o_busy_cnt 0.
